// File: rtl/down_cntr_load_if.sv
// down_cntr_load_if
// Control and status bundle for the loadable down counter.
//   master: drives en, load, load_val, auto_reload; observes Q, tc, busy
//   slave : the counter itself; observes the controls, drives Q, tc, busy
//   en          count enable
//   load        synchronous load strobe (priority over en)
//   load_val    start / reload value
//   auto_reload 1 = reload and keep running on expiry, 0 = stop
//   Q           current count (registered)
//   tc          one-cycle terminal-count pulse (registered)
//   busy        counter is running (registered)
interface down_cntr_load_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (
    output en, load, load_val, auto_reload,
    input  Q, tc, busy
  );

  modport slave (
    input  en, load, load_val, auto_reload,
    output Q, tc, busy
  );
endinterface

// File: rtl/down_cntr_load.sv
// down_cntr_load
// Synchronous loadable down counter with a one-cycle terminal-count pulse
// and optional auto-reload. Used as a programmable interval timer and
// divide-by-N source (with auto-reload and value N, tc fires every N+1
// enabled cycles).
//   clk  rising-edge clock for all state
//   rst  asynchronous reset, active low
//   bus  down_cntr_load_if.slave (en, load, load_val, auto_reload -> Q, tc, busy)
module down_cntr_load #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  down_cntr_load_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;

  // Priority: load, then the three RUN+en cases keyed on the current count.
  // Q==0 while RUN only happens right after an auto-reload expiry, so that
  // step restores the reload value instead of decrementing, which keeps the
  // count from ever wrapping to all-ones.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      q_d      = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && bus.en) begin
      if (q_q > ONE) begin
        q_d = q_q - ONE;
      end else if (q_q == ONE) begin
        q_d     = '0;
        tc_d    = 1'b1;
        state_d = bus.auto_reload ? RUN : IDLE;
      end else begin
        q_d = reload_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == RUN);

endmodule

// File: tb/tb_down_cntr_load.sv
module tb_down_cntr_load;

  localparam int W = 4;

  logic clk;
  logic rst;

  down_cntr_load_if #(.WIDTH(W)) bus ();

  down_cntr_load #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: while running, the count is a position in a cycle of
  // length N+1 measured from the last load (N, N-1, ..., 0, N, ...).
  int m_n;     // last loaded value
  int m_k;     // enabled steps taken since the last load
  int m_q;     // visible count
  bit m_run;
  bit m_tc;

  function automatic void model_reset();
    m_n = 0; m_k = 0; m_q = 0; m_run = 0; m_tc = 0;
  endfunction

  function automatic void model_edge(bit e, bit l, int v, bit a);
    m_tc = 0;
    if (l) begin
      m_n = v; m_k = 0; m_q = v; m_run = (v != 0);
    end else if (m_run && e) begin
      m_k = m_k + 1;
      m_q = m_n - (m_k % (m_n + 1));
      if (m_q == 0) begin
        m_tc = 1;
        if (!a) m_run = 0;
      end
    end
  endfunction

  function automatic logic [W+1:0] model_vec();
    logic [W-1:0] qv;
    qv = m_q[W-1:0];
    return {qv, m_tc, m_run};
  endfunction

  function automatic logic [W+1:0] dut_vec();
    return {bus.Q, bus.tc, bus.busy};
  endfunction

  // Drive inputs on the falling edge, advance the model on the rising edge,
  // leave time at posedge+1 for sampling.
  task automatic step(input bit e, input bit l, input int v, input bit a);
    @(negedge clk);
    bus.en          = e;
    bus.load        = l;
    bus.load_val    = v[W-1:0];
    bus.auto_reload = a;
    @(posedge clk);
    model_edge(e, l, v, a);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.auto_reload = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec() !== {{W{1'b0}}, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got Q=%0d tc=%0b busy=%0b, expected 0/0/0", bus.Q, bus.tc, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_idle_en: got %b expected %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_one_shot();
    int exp_q[9] = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
    step(1, 1, 5, 0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(1, 0, $urandom_range(15), 0);
      n_checks++;
      if (dut_vec() !== model_vec() || int'(bus.Q) != exp_q[i] || bus.tc !== (i == 5)) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: got Q=%0d tc=%0b busy=%0b, expected Q=%0d vec=%b",
                 i, bus.Q, bus.tc, bus.busy, exp_q[i], model_vec());
      end
    end
  endtask

  task automatic test_auto_reload();
    int tc_seen = 0;
    step(1, 1, 3, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, $urandom_range(15), 1);
      n_checks++;
      if (dut_vec() !== model_vec() || int'(bus.Q) != 3 - ((i + 1) % 4) || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL auto_reload[%0d]: got Q=%0d tc=%0b busy=%0b, expected %b",
                 i, bus.Q, bus.tc, bus.busy, model_vec());
      end
      if (bus.tc === 1'b1) tc_seen++;
    end
    n_checks++;
    if (tc_seen != 3) begin
      n_fail++;
      $display("FAIL auto_reload_tc_count: got %0d pulses, expected 3", tc_seen);
    end
  endtask

  task automatic test_enable_gating();
    bit en_seq[7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_q[7]  = '{3, 3, 3, 2, 1, 1, 0};
    step(0, 1, 4, 0);
    for (int i = 0; i < 7; i++) begin
      step(en_seq[i], 0, 0, 0);
      n_checks++;
      if (dut_vec() !== model_vec() || int'(bus.Q) != exp_q[i] || bus.tc !== (i == 6)) begin
        n_fail++;
        $display("FAIL enable_gating[%0d]: got Q=%0d tc=%0b, expected Q=%0d tc=%0b",
                 i, bus.Q, bus.tc, exp_q[i], (i == 6));
      end
    end
  endtask

  task automatic test_load_priority();
    step(1, 1, 6, 0);
    repeat (5) step(1, 0, 0, 0);
    n_checks++;
    if (bus.Q !== 4'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_prio_pre: got Q=%0d busy=%0b, expected Q=1 busy=1", bus.Q, bus.busy);
    end
    step(1, 1, 9, 0);
    n_checks++;
    if (dut_vec() !== {4'd9, 1'b0, 1'b1} || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL load_prio_win: got Q=%0d tc=%0b busy=%0b, expected 9/0/1", bus.Q, bus.tc, bus.busy);
    end
    step(1, 1, 0, 1);
    n_checks++;
    if (dut_vec() !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_zero: got Q=%0d tc=%0b busy=%0b, expected 0/0/0", bus.Q, bus.tc, bus.busy);
    end
    step(1, 0, 0, 1);
    n_checks++;
    if (dut_vec() !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_zero_hold: got Q=%0d tc=%0b busy=%0b, expected 0/0/0", bus.Q, bus.tc, bus.busy);
    end
  endtask

  task automatic test_mid_run_reset();
    step(1, 1, 7, 1);
    repeat (3) step(1, 0, 0, 1);
    n_checks++;
    if (bus.Q !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got Q=%0d, expected 4", bus.Q);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got Q=%0d tc=%0b busy=%0b, expected 0/0/0", bus.Q, bus.tc, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1);
      n_checks++;
      if (dut_vec() !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL mid_reset_after[%0d]: got Q=%0d busy=%0b, expected 0/0", i, bus.Q, bus.busy);
      end
    end
  endtask

  task automatic test_full_range();
    int last_tc = -1;
    int prev_q;
    step(1, 1, 15, 1);
    prev_q = int'(bus.Q);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 1);
      n_checks++;
      if (dut_vec() !== model_vec() || (prev_q == 0 && int'(bus.Q) != 15) ||
          (prev_q != 0 && int'(bus.Q) != prev_q - 1)) begin
        n_fail++;
        $display("FAIL full_range[%0d]: got Q=%0d (prev %0d) tc=%0b, expected %b",
                 i, bus.Q, prev_q, bus.tc, model_vec());
      end
      if (bus.tc === 1'b1) begin
        if (last_tc >= 0) begin
          n_checks++;
          if (i - last_tc != 16) begin
            n_fail++;
            $display("FAIL full_range_period: got %0d cycles, expected 16", i - last_tc);
          end
        end
        last_tc = i;
      end
      prev_q = int'(bus.Q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, $urandom_range(15) == 0,
           $urandom_range(15), $urandom_range(1));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got Q=%0d tc=%0b busy=%0b, expected %b",
                 i, bus.Q, bus.tc, bus.busy, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_load_priority();
    test_mid_run_reset();
    test_full_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
